// File: rtl/stack_datapath_if.sv
// Data-memory port shared by the datapath's load/store path and the stack sequencer.
// The master side is the datapath; the slave side is the memory (or a wait-state wrapper).
interface stack_datapath_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic [ADDR_W-1:0] data_mem_addr;
   logic [DATA_W-1:0] data_mem_dout;
   logic [DATA_W-1:0] data_mem_din;
   logic              data_mem_rd;
   logic              data_mem_wr;
   logic              data_mem_ack;

   modport master (
      output data_mem_addr, data_mem_dout, data_mem_rd, data_mem_wr,
      input  data_mem_din, data_mem_ack
   );

   modport slave (
      input  data_mem_addr, data_mem_dout, data_mem_rd, data_mem_wr,
      output data_mem_din, data_mem_ack
   );
endinterface

// File: rtl/stack_datapath.sv
// Register file plus an empty-descending hardware stack (PUSH/POP/CALL/RET) that borrows
// the data-memory port from ordinary load/store while an operation is in flight.
module stack_datapath #(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       ADDR_W      = 8,
   parameter int unsigned       REG_CNT     = 16,
   parameter logic [ADDR_W-1:0] STACK_BASE  = 8'hFF,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0,
   localparam int unsigned      RA_W        = $clog2(REG_CNT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DATA_W-1:0]  const_data,
   input  logic               wr_data_sel,
   input  logic               addr_op2_sel,
   input  logic [RA_W-1:0]    reg_addr_x,
   input  logic [RA_W-1:0]    reg_addr_y,
   input  logic               reg_wr_en,
   input  logic [DATA_W-1:0]  alu_result,
   output logic [DATA_W-1:0]  operand1,
   output logic [DATA_W-1:0]  operand2,
   output logic [ADDR_W-1:0]  jump_address,
   input  logic               ctrl_mem_rd,
   input  logic               ctrl_mem_wr,
   stack_datapath_if.master   mem,
   input  logic [2:0]         stack_op,
   input  logic               stack_req,
   input  logic [ADDR_W-1:0]  ret_pc,
   output logic               stack_busy,
   output logic               stack_done,
   output logic               stack_err,
   output logic               pc_load,
   output logic [ADDR_W-1:0]  pc_value,
   output logic [ADDR_W-1:0]  sp,
   output logic               stack_empty,
   output logic               stack_full
);
   typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

   localparam logic [2:0] OP_PUSH = 3'b001;
   localparam logic [2:0] OP_POP  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [ADDR_W-1:0] SP_FULL = STACK_LIMIT - ADDR_W'(1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] regs_q [REG_CNT];
   logic [ADDR_W-1:0] sp_q, sp_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] jump_q;
   logic [2:0]        op_q;
   logic [RA_W-1:0]   dst_q;
   logic [DATA_W-1:0] data_q;
   logic              err_q, err_d;
   logic              capture;
   logic              req_err;
   logic              op_is_push;
   logic              ack_mem;

   assign operand1     = regs_q[reg_addr_x];
   assign operand2     = addr_op2_sel ? regs_q[reg_addr_y] : const_data;
   assign jump_address = operand2[ADDR_W-1:0];

   assign op_is_push  = (op_q == OP_PUSH) || (op_q == OP_CALL);
   assign stack_empty = (sp_q == STACK_BASE);
   assign stack_full  = (sp_q == SP_FULL);
   assign ack_mem     = (state_q == S_MEM) && mem.data_mem_ack;

   always_comb begin
      case (stack_op)
         OP_PUSH, OP_CALL: req_err = stack_full;
         OP_POP, OP_RET:   req_err = stack_empty;
         default:          req_err = 1'b1;
      endcase
   end

   // Stack sequencer owns the port in MEM; DONE keeps the strobes quiet for its one cycle.
   always_comb begin
      mem.data_mem_addr = jump_address;
      mem.data_mem_dout = operand1;
      mem.data_mem_rd   = ctrl_mem_rd;
      mem.data_mem_wr   = ctrl_mem_wr;
      if (state_q == S_MEM) begin
         mem.data_mem_addr = op_is_push ? sp_q : sp_q + ADDR_W'(1);
         mem.data_mem_dout = data_q;
         mem.data_mem_rd   = !op_is_push;
         mem.data_mem_wr   = op_is_push;
      end else if (state_q == S_DONE) begin
         mem.data_mem_rd = 1'b0;
         mem.data_mem_wr = 1'b0;
      end
   end

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      sp_d    = sp_q;
      pc_d    = pc_q;
      err_d   = 1'b0;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (stack_req) begin
               if (req_err) begin
                  err_d = 1'b1;
               end else begin
                  capture = 1'b1;
                  state_d = S_MEM;
               end
            end
         end
         S_MEM: begin
            if (mem.data_mem_ack) begin
               sp_d    = op_is_push ? sp_q - ADDR_W'(1) : sp_q + ADDR_W'(1);
               state_d = S_DONE;
               if (op_q == OP_RET)  pc_d = mem.data_mem_din[ADDR_W-1:0];
               if (op_q == OP_CALL) pc_d = jump_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sp_q    <= STACK_BASE;
         pc_q    <= '0;
         err_q   <= 1'b0;
         op_q    <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         jump_q  <= '0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
         if (capture) begin
            op_q   <= stack_op;
            dst_q  <= reg_addr_x;
            data_q <= (stack_op == OP_CALL) ? DATA_W'(ret_pc) : operand1;
            jump_q <= jump_address;
         end
      end
   end

   // NOTE: the register file is small flop storage that must read as zero after reset,
   // so it is reset explicitly rather than left to power-up contents like a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(REG_CNT); i++) regs_q[i] <= '0;
      end else if ((state_q == S_IDLE) && reg_wr_en) begin
         regs_q[reg_addr_x] <= wr_data_sel ? mem.data_mem_din : alu_result;
      end else if (ack_mem && (op_q == OP_POP)) begin
         regs_q[dst_q] <= mem.data_mem_din;
      end
   end

   assign stack_busy = (state_q != S_IDLE);
   assign stack_done = (state_q == S_DONE) || err_q;
   assign stack_err  = err_q;
   assign pc_load    = (state_q == S_DONE) && ((op_q == OP_CALL) || (op_q == OP_RET));
   assign pc_value   = pc_q;
   assign sp         = sp_q;
endmodule

// File: tb/tb_stack_datapath.sv
// Directed bench for stack_datapath: idle datapath vectors plus stack sequences against
// a wait-state memory model whose ack delay is set per operation.
module tb_stack_datapath;
   localparam logic [2:0] OP_PUSH = 3'b001;
   localparam logic [2:0] OP_POP  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_RSV  = 3'b111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] const_data, alu_result, ret_pc;
   logic       wr_data_sel, addr_op2_sel, reg_wr_en, ctrl_mem_rd, ctrl_mem_wr, stack_req;
   logic [3:0] reg_addr_x, reg_addr_y;
   logic [2:0] stack_op;
   logic [7:0] operand1, operand2, jump_address, pc_value, sp;
   logic       stack_busy, stack_done, stack_err, pc_load, stack_empty, stack_full;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stack_datapath_if #(.DATA_W(8), .ADDR_W(8)) mif ();

   stack_datapath dut (
      .clk(clk), .rst_n(rst_n), .const_data(const_data), .wr_data_sel(wr_data_sel),
      .addr_op2_sel(addr_op2_sel), .reg_addr_x(reg_addr_x), .reg_addr_y(reg_addr_y),
      .reg_wr_en(reg_wr_en), .alu_result(alu_result), .operand1(operand1),
      .operand2(operand2), .jump_address(jump_address), .ctrl_mem_rd(ctrl_mem_rd),
      .ctrl_mem_wr(ctrl_mem_wr), .mem(mif), .stack_op(stack_op), .stack_req(stack_req),
      .ret_pc(ret_pc), .stack_busy(stack_busy), .stack_done(stack_done),
      .stack_err(stack_err), .pc_load(pc_load), .pc_value(pc_value), .sp(sp),
      .stack_empty(stack_empty), .stack_full(stack_full)
   );

   // Memory model: ack after ack_delay extra strobe cycles, write on the ack edge.
   logic [7:0] mem_q [256];
   int         ack_delay = 0;
   int         wait_cnt = 0;

   assign mif.data_mem_ack = (mif.data_mem_rd || mif.data_mem_wr) && (wait_cnt >= ack_delay);
   assign mif.data_mem_din = mem_q[mif.data_mem_addr];

   always @(posedge clk) begin
      if (mif.data_mem_wr && mif.data_mem_ack) mem_q[mif.data_mem_addr] <= mif.data_mem_dout;
      if ((mif.data_mem_rd || mif.data_mem_wr) && !mif.data_mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr_reg(input logic [3:0] rx, input logic [7:0] val);
      reg_addr_x  = rx;
      alu_result  = val;
      wr_data_sel = 1'b0;
      reg_wr_en   = 1'b1;
      @(posedge clk); #1;
      reg_wr_en = 1'b0;
   endtask

   // Results of the last run_op, observed on falling edges.
   int         r_done_cyc, r_busy, r_rd, r_wr, r_err, r_pcload;
   logic       r_addr_ok;
   logic [7:0] r_dout, r_pc;

   task automatic run_op(input logic [2:0] op, input logic [3:0] rx, input int delay,
                         input bit noise, input logic [7:0] exp_addr);
      ack_delay  = delay;
      stack_req  = 1'b1;
      stack_op   = op;
      reg_addr_x = rx;
      r_done_cyc = -1;
      r_busy = 0; r_rd = 0; r_wr = 0; r_err = 0; r_pcload = 0;
      r_addr_ok = 1'b1; r_dout = '0; r_pc = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c > 0 && stack_busy) r_busy++;
         if (c > 0 && mif.data_mem_rd) r_rd++;
         if (c > 0 && mif.data_mem_wr) r_wr++;
         if (c > 0 && (mif.data_mem_rd || mif.data_mem_wr)) begin
            if (mif.data_mem_addr !== exp_addr) r_addr_ok = 1'b0;
            r_dout = mif.data_mem_dout;
         end
         if (stack_err) r_err++;
         if (pc_load) begin
            r_pcload++;
            r_pc = pc_value;
         end
         if (c > 0 && stack_done) begin
            r_done_cyc = c;
            break;
         end
         @(posedge clk); #1;
         stack_req = 1'b0; reg_wr_en = 1'b0; ctrl_mem_rd = 1'b0; ctrl_mem_wr = 1'b0;
         if (noise && (c + 1 <= delay)) begin
            stack_req = 1'b1; stack_op = OP_POP; ctrl_mem_rd = 1'b1; ctrl_mem_wr = 1'b1;
         end
      end
      @(posedge clk); #1;
      stack_req = 1'b0; ctrl_mem_rd = 1'b0; ctrl_mem_wr = 1'b0;
   endtask

   typedef struct {
      logic       sel, c_rd, c_wr;
      logic [7:0] k;
      logic [3:0] x, y;
      logic [7:0] e_op1, e_op2, e_dout;
      logic       e_rd, e_wr;
   } vec_t;

   vec_t vecs [4];
   int   fill_bad;

   initial begin
      rst_n = 1'b0; const_data = '0; alu_result = '0; ret_pc = '0;
      wr_data_sel = 0; addr_op2_sel = 0; reg_wr_en = 0; ctrl_mem_rd = 0; ctrl_mem_wr = 0;
      stack_req = 0; reg_addr_x = '0; reg_addr_y = '0; stack_op = '0;

      #12;
      check("rst_sp", sp, 8'hFF);
      check("rst_empty", stack_empty, 1);
      check("rst_full", stack_full, 0);
      check("rst_strobes", {mif.data_mem_rd, mif.data_mem_wr, pc_load, stack_done, stack_err}, 0);
      check("rst_busy", stack_busy, 0);
      check("rst_pc", pc_value, 0);
      check("rst_reg", operand1, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      wr_reg(4'd1, 8'h11);
      wr_reg(4'd2, 8'h22);
      wr_reg(4'd3, 8'h5A);
      wr_reg(4'd4, 8'h10);

      // Idle combinational datapath.
      vecs[0] = '{0, 1, 0, 8'h33, 4'd1, 4'd2, 8'h11, 8'h33, 8'h11, 1, 0};
      vecs[1] = '{1, 0, 1, 8'h33, 4'd2, 4'd3, 8'h22, 8'h5A, 8'h22, 0, 1};
      vecs[2] = '{1, 0, 0, 8'h77, 4'd3, 4'd0, 8'h5A, 8'h00, 8'h5A, 0, 0};
      vecs[3] = '{0, 1, 1, 8'hFF, 4'd0, 4'd4, 8'h00, 8'hFF, 8'h00, 1, 1};
      for (int i = 0; i < 4; i++) begin
         addr_op2_sel = vecs[i].sel; ctrl_mem_rd = vecs[i].c_rd; ctrl_mem_wr = vecs[i].c_wr;
         const_data = vecs[i].k; reg_addr_x = vecs[i].x; reg_addr_y = vecs[i].y;
         #1;
         check($sformatf("vec%0d_op1", i), operand1, vecs[i].e_op1);
         check($sformatf("vec%0d_op2", i), operand2, vecs[i].e_op2);
         check($sformatf("vec%0d_jump", i), jump_address, vecs[i].e_op2);
         check($sformatf("vec%0d_addr", i), mif.data_mem_addr, vecs[i].e_op2);
         check($sformatf("vec%0d_dout", i), mif.data_mem_dout, vecs[i].e_dout);
         check($sformatf("vec%0d_strb", i), {mif.data_mem_rd, mif.data_mem_wr},
               {vecs[i].e_rd, vecs[i].e_wr});
      end
      ctrl_mem_rd = 0; ctrl_mem_wr = 0; addr_op2_sel = 0;
      @(posedge clk); #1;

      // Idle store R2 -> mem[0x10], then idle load through regY address into R9.
      const_data = 8'h10; reg_addr_x = 4'd2; ctrl_mem_wr = 1; ack_delay = 0;
      @(posedge clk); #1;
      ctrl_mem_wr = 0;
      addr_op2_sel = 1; reg_addr_y = 4'd4; ctrl_mem_rd = 1; wr_data_sel = 1;
      reg_addr_x = 4'd9; reg_wr_en = 1;
      #1;
      check("ld_addr", mif.data_mem_addr, 8'h10);
      check("ld_rd", mif.data_mem_rd, 1);
      @(posedge clk); #1;
      ctrl_mem_rd = 0; reg_wr_en = 0; wr_data_sel = 0; addr_op2_sel = 0;
      #1;
      check("ld_r9", operand1, 8'h22);

      // PUSH R3, zero wait states.
      run_op(OP_PUSH, 4'd3, 0, 0, 8'hFF);
      check("push_done_cyc", r_done_cyc, 2);
      check("push_wr_cnt", r_wr, 1);
      check("push_rd_cnt", r_rd, 0);
      check("push_addr", r_addr_ok, 1);
      check("push_dout", r_dout, 8'h5A);
      check("push_mem", mem_q[8'hFF], 8'h5A);
      check("push_sp", sp, 8'hFE);
      check("push_empty", stack_empty, 0);

      // POP into R7 with ack in the third strobe cycle.
      run_op(OP_POP, 4'd7, 2, 0, 8'hFF);
      check("pop_rd_cnt", r_rd, 3);
      check("pop_busy", r_busy, 4);
      check("pop_done_cyc", r_done_cyc, 4);
      check("pop_addr", r_addr_ok, 1);
      check("pop_sp", sp, 8'hFF);
      reg_addr_x = 4'd7; #1;
      check("pop_r7", operand1, 8'h5A);

      // PUSH with a same-cycle register write: pushed value is the pre-write R3.
      alu_result = 8'h77; wr_data_sel = 0; reg_wr_en = 1;
      run_op(OP_PUSH, 4'd3, 0, 0, 8'hFF);
      check("pushwr_dout", r_dout, 8'h5A);
      reg_addr_x = 4'd3; #1;
      check("pushwr_r3", operand1, 8'h77);
      run_op(OP_POP, 4'd5, 1, 0, 8'hFE);
      reg_addr_x = 4'd5; #1;
      check("pushwr_r5", operand1, 8'h5A);
      check("pushwr_sp", sp, 8'hFF);

      // Requests and ctrl strobes issued while busy are ignored.
      const_data = 8'h44;
      run_op(OP_PUSH, 4'd1, 2, 1, 8'hFF);
      check("noise_rd_cnt", r_rd, 0);
      check("noise_wr_cnt", r_wr, 3);
      check("noise_addr", r_addr_ok, 1);
      check("noise_done_cyc", r_done_cyc, 4);
      @(posedge clk); #1;
      check("noise_busy", stack_busy, 0);
      check("noise_sp", sp, 8'hFE);
      run_op(OP_POP, 4'd6, 0, 0, 8'hFE);
      reg_addr_x = 4'd6; #1;
      check("noise_r6", operand1, 8'h11);

      // CALL then RET.
      ret_pc = 8'h21; const_data = 8'h80; addr_op2_sel = 0;
      run_op(OP_CALL, 4'd0, 0, 0, 8'hFF);
      check("call_dout", r_dout, 8'h21);
      check("call_mem", mem_q[8'hFF], 8'h21);
      check("call_pcload", r_pcload, 1);
      check("call_pc", r_pc, 8'h80);
      check("call_sp", sp, 8'hFE);
      const_data = 8'h00;
      run_op(OP_RET, 4'd0, 1, 0, 8'hFF);
      check("ret_rd_cnt", r_rd, 2);
      check("ret_pcload", r_pcload, 1);
      check("ret_pc", r_pc, 8'h21);
      check("ret_sp", sp, 8'hFF);

      // Error cases: POP/RET on empty, reserved codes.
      run_op(OP_POP, 4'd7, 0, 0, 8'hFF);
      check("pope_err", r_err, 1);
      check("pope_done_cyc", r_done_cyc, 1);
      check("pope_strobes", r_rd + r_wr, 0);
      check("pope_sp", sp, 8'hFF);
      run_op(OP_RET, 4'd0, 0, 0, 8'hFF);
      check("rete_err", r_err, 1);
      run_op(OP_RSV, 4'd1, 0, 0, 8'hFF);
      check("rsv_err", r_err, 1);
      check("rsv_strobes", r_rd + r_wr, 0);
      check("rsv_sp", sp, 8'hFF);
      run_op(3'b000, 4'd1, 0, 0, 8'hFF);
      check("rsv0_err", r_err, 1);

      // Fill the stack: 64 pushes, then overflow attempts.
      fill_bad = 0;
      for (int i = 0; i < 64; i++) begin
         run_op(OP_PUSH, 4'd1, 0, 0, 8'(255 - i));
         if (!r_addr_ok || r_done_cyc != 2 || r_err != 0) fill_bad++;
      end
      check("fill_pushes", fill_bad, 0);
      check("fill_sp", sp, 8'hBF);
      check("fill_full", stack_full, 1);
      check("fill_mem_c0", mem_q[8'hC0], 8'h11);
      run_op(OP_PUSH, 4'd1, 0, 0, 8'hBF);
      check("ovf_err", r_err, 1);
      check("ovf_done_cyc", r_done_cyc, 1);
      check("ovf_strobes", r_rd + r_wr, 0);
      check("ovf_sp", sp, 8'hBF);
      run_op(OP_CALL, 4'd0, 0, 0, 8'hBF);
      check("ovf_call_err", r_err, 1);

      // Reset in the middle of a POP wait.
      ack_delay = 5; stack_req = 1; stack_op = OP_POP; reg_addr_x = 4'd8;
      @(posedge clk); #1;
      stack_req = 0;
      @(negedge clk);
      check("rpop_rd", mif.data_mem_rd, 1);
      check("rpop_addr", mif.data_mem_addr, 8'hC0);
      #2 rst_n = 1'b0;
      #1;
      check("rpop_rd_drop", mif.data_mem_rd, 0);
      check("rpop_busy", stack_busy, 0);
      check("rpop_sp", sp, 8'hFF);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a PUSH wait.
      wr_reg(4'd1, 8'h99);
      ack_delay = 5; stack_req = 1; stack_op = OP_PUSH; reg_addr_x = 4'd1;
      @(posedge clk); #1;
      stack_req = 0;
      @(negedge clk);
      check("rpush_wr", mif.data_mem_wr, 1);
      check("rpush_dout", mif.data_mem_dout, 8'h99);
      #2 rst_n = 1'b0;
      #1;
      check("rpush_wr_drop", mif.data_mem_wr, 0);
      check("rpush_sp", sp, 8'hFF);
      check("rpush_reg", operand1, 0);
      check("rpush_pc", pc_value, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/stack_datapath.md
Name: stack_datapath

Overview:
- Next-generation CPU datapath: a parametrised register file plus a hardware stack engine (SP register, multi-cycle PUSH/POP/CALL/RET sequencer) that shares the data-memory port with ordinary load/store.
- Sits between the controller and data memory. The ALU is instantiated outside: this block exports both operands and takes the ALU result back.
- Stack memory accesses use a req/ack handshake, so wait-state memories are supported.

Parameters:
- DATA_W, 8, register/memory data width.
- ADDR_W, 8, data-memory address width; must satisfy ADDR_W <= DATA_W.
- REG_CNT, 16, number of registers; RA_W = $clog2(REG_CNT).
- STACK_BASE, 8'hFF, SP reset value; this is the empty position.
- STACK_LIMIT, 8'hC0, lowest writable stack address; must be < STACK_BASE.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- const_data  in  DATA_W  instruction constant.
- wr_data_sel  in  1  register write source: 0 = alu_result, 1 = data_mem_din.
- addr_op2_sel  in  1  operand2/address source: 0 = const_data, 1 = reg Y.
- reg_addr_x  in  RA_W  X port address; also the write address.
- reg_addr_y  in  RA_W  Y port address.
- reg_wr_en  in  1  register write enable.
- alu_result  in  DATA_W  result from the external ALU.
- operand1  out  DATA_W  reg X data.
- operand2  out  DATA_W  selected second operand.
- jump_address  out  ADDR_W  operand2[ADDR_W-1:0].
- ctrl_mem_rd, ctrl_mem_wr  in  1  controller load/store strobes.
- data_mem_addr  out  ADDR_W  memory address.
- data_mem_dout  out  DATA_W  memory write data.
- data_mem_din  in  DATA_W  memory read data.
- data_mem_rd, data_mem_wr  out  1  memory strobes.
- data_mem_ack  in  1  memory acknowledge; sampled during stack accesses only.
- stack_op  in  3  001 PUSH, 010 POP, 011 CALL, 100 RET; all other codes reserved.
- stack_req  in  1  one-cycle stack operation request.
- ret_pc  in  ADDR_W  return address pushed by CALL.
- stack_busy  out  1  sequencer not in IDLE.
- stack_done  out  1  one-cycle completion pulse.
- stack_err  out  1  one-cycle error pulse.
- pc_load  out  1  one-cycle PC load strobe.
- pc_value  out  ADDR_W  PC value for the controller.
- sp  out  ADDR_W  current SP.
- stack_empty, stack_full  out  1  stack status flags.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE and SP = STACK_BASE.
  - All registers = 0; pc_value = 0.
  - All strobes and pulses = 0 immediately, including any access in progress.
- Status flags: stack_empty = (SP == STACK_BASE); stack_full = (SP == STACK_LIMIT-1). Stack depth = STACK_BASE - STACK_LIMIT + 1.
- Stack model: empty-descending.
  - PUSH writes mem[SP], then SP--.
  - POP reads mem[SP+1], then SP++.
- IDLE datapath (combinational):
  - operand2 = addr_op2_sel ? regY : const_data.
  - data_mem_addr = operand2[ADDR_W-1:0].
  - data_mem_dout = regX.
  - data_mem_rd/data_mem_wr = ctrl_mem_rd/ctrl_mem_wr.
  - Register write data = wr_data_sel ? data_mem_din : alu_result, written on the clock edge when reg_wr_en = 1.
- Request in IDLE (stack_req = 1):
  - Capture op, reg_addr_x, push data (regX for PUSH; ret_pc zero-extended for CALL) and jump_address.
  - A same-cycle reg_wr_en still writes, and PUSH captures the pre-write value.
- Error check, performed in IDLE:
  - Reserved op, PUSH/CALL when stack_full, or POP/RET when stack_empty all cause an error.
  - On error: stack_err and stack_done pulse in the next cycle, no memory access, SP unchanged, state stays IDLE.
- MEM state:
  - Drives data_mem_addr = SP (push) or SP+1 (pop) and data_mem_dout = captured data.
  - Asserts data_mem_wr (PUSH/CALL) or data_mem_rd (POP/RET), held until data_mem_ack.
  - ctrl_mem_* and reg_wr_en are ignored; stack_req is ignored while busy.
- On the ack edge:
  - SP is updated.
  - POP writes data_mem_din into the captured register.
  - RET latches pc_value = din[ADDR_W-1:0]; CALL latches pc_value = captured jump_address.
  - State goes to DONE.
- DONE state (one cycle): stack_done = 1; pc_load = 1 for CALL/RET only; then return to IDLE.
- Latency: request at cycle 0, strobe from cycle 1, ack at cycle k, done at k+1. With zero wait states, done arrives at cycle 2.
- SP arithmetic is modulo 2^ADDR_W. Overflow and underflow are blocked by the error check, so no wrap occurs in legal use.

Test Plan:
- Reset → SP=FF, stack_empty=1, all strobes 0. PUSH R3=0x5A with ack in the strobe cycle → mem[FF] written with 0x5A, SP=FE, stack_done at cycle 2.
- Then POP into R7, with ack delayed 3 cycles → data_mem_rd held at addr FF for 3 cycles, R7=0x5A, SP=FF, busy for 4 cycles.
- CALL with ret_pc=0x21, const target 0x80 → mem[FF]=0x21, pc_load with pc_value=0x80. Then RET → pc_load with pc_value=0x21, SP back to FF.
- POP on empty stack; 64 PUSHes followed by a 65th; reserved op 111 → each gives stack_err+stack_done, SP unchanged, no memory strobe. stack_full=1 at SP=BF.
- rst_n asserted during MEM wait → data_mem_wr drops immediately, SP=FF. A stack_req and ctrl_mem_wr issued while busy are ignored.
- Idle load: addr_op2_sel=1, regY=0x10, ctrl_mem_rd=1, wr_data_sel=1 → data_mem_addr=0x10, din written to regX on the same edge.
